// File: rtl/mem_tile_addresses_generator.sv
// Tiled operand address generator: walks an M x N operand in ARRAY_HEIGHT x ELEMENTS tiles, one row address per beat.
// Optional stall counter output enabled by defining MEM_ADDR_GEN_PERF_EN.
module mem_tile_addresses_generator #(
   parameter int BUS_WIDTH_BYTES  = 32,
   parameter int DATA_WIDTH_BYTES = 1,
   parameter int ARRAY_HEIGHT     = 4,
   parameter int ADDR_WIDTH       = 16,
   parameter int DIM_WIDTH        = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic                  col_major_i,
   input  logic [DIM_WIDTH-1:0]  m,
   input  logic [DIM_WIDTH-1:0]  n,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] row_pitch,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  addr_valid_o,
   input  logic                  addr_ready_i,
   output logic                  pad_o,
   output logic                  last_o,
   output logic                  busy_o,
   output logic                  done_o
`ifdef MEM_ADDR_GEN_PERF_EN
   ,
   output logic [31:0]           stall_cnt_o
`endif
);

   localparam int ELEMENTS = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES;
   localparam int CW       = DIM_WIDTH + 1;
   localparam int IW       = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
   localparam int DSH      = $clog2(DATA_WIDTH_BYTES);
   localparam int HSH      = $clog2(ARRAY_HEIGHT);

   localparam logic [CW-1:0]         ELEM_C = CW'(ELEMENTS);
   localparam logic [CW-1:0]         HGT_C  = CW'(ARRAY_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] BUS_A  = ADDR_WIDTH'(BUS_WIDTH_BYTES);
   localparam logic [IW-1:0]         I_LAST = IW'(ARRAY_HEIGHT - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EMIT   = 2'd1;
   localparam logic [1:0] S_ADV    = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   logic [1:0]            state_q, state_d;
   logic                  prime_q, prime_d;
   logic [CW-1:0]         m_q, m_d, n_q, n_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d, p_q, p_d, hp_q, hp_d;
   logic                  col_major_q, col_major_d;
   logic [CW-1:0]         r0_q, r0_d, c0_q, c0_d;
   logic [ADDR_WIDTH-1:0] roff_q, roff_d, coff_q, coff_d;
   logic [IW-1:0]         i_q, i_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  valid_q, valid_d, pad_q, pad_d, last_q, last_d;
   logic                  busy_q, busy_d, done_q, done_d;

   logic [CW-1:0]         r0_nx, c0_nx;
   logic [ADDR_WIDTH-1:0] roff_nx, coff_nx;
   logic                  row_wrap, col_wrap, fin_cur, fin_nx;
   logic [IW-1:0]         i_inc;

   // roff tracks r0*P and coff tracks c0*DATA_WIDTH_BYTES so every address is a sum, never a product.
   always_comb begin
      row_wrap = (r0_q + HGT_C) >= m_q;
      col_wrap = (c0_q + ELEM_C) >= n_q;
      fin_cur  = row_wrap && col_wrap;
      i_inc    = i_q + 1'b1;
      r0_nx    = r0_q;
      c0_nx    = c0_q;
      roff_nx  = roff_q;
      coff_nx  = coff_q;
      if (col_major_q) begin
         if (row_wrap) begin
            r0_nx   = '0;
            roff_nx = '0;
            c0_nx   = c0_q + ELEM_C;
            coff_nx = coff_q + BUS_A;
         end else begin
            r0_nx   = r0_q + HGT_C;
            roff_nx = roff_q + hp_q;
         end
      end else begin
         if (col_wrap) begin
            c0_nx   = '0;
            coff_nx = '0;
            r0_nx   = r0_q + HGT_C;
            roff_nx = roff_q + hp_q;
         end else begin
            c0_nx   = c0_q + ELEM_C;
            coff_nx = coff_q + BUS_A;
         end
      end
      fin_nx = ((r0_nx + HGT_C) >= m_q) && ((c0_nx + ELEM_C) >= n_q);
   end

   always_comb begin
      state_d     = state_q;
      prime_d     = prime_q;
      m_d         = m_q;
      n_d         = n_q;
      base_d      = base_q;
      p_d         = p_q;
      hp_d        = hp_q;
      col_major_d = col_major_q;
      r0_d        = r0_q;
      c0_d        = c0_q;
      roff_d      = roff_q;
      coff_d      = coff_q;
      i_d         = i_q;
      addr_d      = addr_q;
      valid_d     = valid_q;
      pad_d       = pad_q;
      last_d      = last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               m_d         = {1'b0, m};
               n_d         = {1'b0, n};
               base_d      = base_addr;
               p_d         = (row_pitch == '0) ? (ADDR_WIDTH'(n) << DSH) : row_pitch;
               hp_d        = p_d << HSH;
               col_major_d = col_major_i;
               r0_d        = '0;
               c0_d        = '0;
               roff_d      = '0;
               coff_d      = '0;
               i_d         = '0;
               prime_d     = 1'b1;
               busy_d      = 1'b1;
               state_d     = ((m == '0) || (n == '0)) ? S_FINISH : S_EMIT;
            end
         end
         S_EMIT: begin
            // The first EMIT cycle only loads the tile-0 address from the latched config.
            if (prime_q) begin
               prime_d = 1'b0;
               addr_d  = base_q + roff_q + coff_q;
               valid_d = 1'b1;
               pad_d   = r0_q >= m_q;
               last_d  = (i_q == I_LAST) && fin_cur;
            end else if (valid_q && addr_ready_i) begin
               if (i_q == I_LAST) begin
                  valid_d = 1'b0;
                  pad_d   = 1'b0;
                  last_d  = 1'b0;
                  if (last_q) begin
                     state_d = S_FINISH;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_ADV;
                  end
               end else begin
                  i_d    = i_inc;
                  addr_d = addr_q + p_q;
                  pad_d  = (r0_q + CW'(i_inc)) >= m_q;
                  last_d = (i_inc == I_LAST) && fin_cur;
               end
            end
         end
         S_ADV: begin
            r0_d    = r0_nx;
            c0_d    = c0_nx;
            roff_d  = roff_nx;
            coff_d  = coff_nx;
            i_d     = '0;
            addr_d  = base_q + roff_nx + coff_nx;
            valid_d = 1'b1;
            pad_d   = r0_nx >= m_q;
            last_d  = (I_LAST == '0) && fin_nx;
            state_d = S_EMIT;
         end
         S_FINISH: begin
            // An empty walk spends one settle cycle here before its done pulse.
            if (prime_q) begin
               prime_d = 1'b0;
               done_d  = 1'b1;
            end else begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort_i && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         prime_d = 1'b0;
         valid_d = 1'b0;
         pad_d   = 1'b0;
         last_d  = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         prime_q     <= 1'b0;
         m_q         <= '0;
         n_q         <= '0;
         base_q      <= '0;
         p_q         <= '0;
         hp_q        <= '0;
         col_major_q <= 1'b0;
         r0_q        <= '0;
         c0_q        <= '0;
         roff_q      <= '0;
         coff_q      <= '0;
         i_q         <= '0;
         addr_q      <= '0;
         valid_q     <= 1'b0;
         pad_q       <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         prime_q     <= prime_d;
         m_q         <= m_d;
         n_q         <= n_d;
         base_q      <= base_d;
         p_q         <= p_d;
         hp_q        <= hp_d;
         col_major_q <= col_major_d;
         r0_q        <= r0_d;
         c0_q        <= c0_d;
         roff_q      <= roff_d;
         coff_q      <= coff_d;
         i_q         <= i_d;
         addr_q      <= addr_d;
         valid_q     <= valid_d;
         pad_q       <= pad_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign addr_o       = addr_q;
   assign addr_valid_o = valid_q;
   assign pad_o        = pad_q;
   assign last_o       = last_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

`ifdef MEM_ADDR_GEN_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == S_IDLE) && start_i) begin
         stall_cnt_d = '0;
      end else if (valid_q && !addr_ready_i && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_tile_addresses_generator.sv
// Bench for mem_tile_addresses_generator: directed tile-walk cases plus randomized walks against a loop-based address model.
module tb_mem_tile_addresses_generator;

   localparam int H = 4;
   localparam int E = 32;
   localparam int D = 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic        col_major_i = 1'b0;
   logic        addr_ready_i = 1'b1;
   logic [15:0] m = '0;
   logic [15:0] n = '0;
   logic [15:0] base_addr = '0;
   logic [15:0] row_pitch = '0;
   logic [15:0] addr_o;
   logic        addr_valid_o, pad_o, last_o, busy_o, done_o;
`ifdef MEM_ADDR_GEN_PERF_EN
   logic [31:0] stall_cnt_o;
`endif

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int done_seen = 0;
   int done_cyc = 0;
   int s_cyc = 0;
   int stall_at = -1;
   bit rand_ready = 1'b0;

   // Expected beats: {addr[15:0], pad, last}
   logic [17:0] exp_q[$];

   logic        prev_v = 1'b0, prev_r = 1'b0, prev_ab = 1'b0, prev_p = 1'b0, prev_l = 1'b0;
   logic [15:0] prev_a = '0;

   mem_tile_addresses_generator dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .col_major_i  (col_major_i),
      .m            (m),
      .n            (n),
      .base_addr    (base_addr),
      .row_pitch    (row_pitch),
      .addr_o       (addr_o),
      .addr_valid_o (addr_valid_o),
      .addr_ready_i (addr_ready_i),
      .pad_o        (pad_o),
      .last_o       (last_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
`ifdef MEM_ADDR_GEN_PERF_EN
      ,
      .stall_cnt_o  (stall_cnt_o)
`endif
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ready generator: random or always-on, with a one-shot 3-cycle stall once acc_cnt hits stall_at
   initial begin
      int stall_left;
      int fired_at;
      stall_left = 0;
      fired_at = -1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_left > 0) begin
            addr_ready_i = 1'b0;
            stall_left--;
         end else if (stall_at >= 0 && acc_cnt == stall_at && fired_at != stall_at) begin
            fired_at = stall_at;
            addr_ready_i = 1'b0;
            stall_left = 2;
         end else begin
            addr_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_v = 1'b0;
      end else begin
         if (done_o) begin
            done_seen++;
            done_cyc = cyc;
         end
         if (prev_v && !prev_r && !prev_ab) begin
            check("hold_valid", addr_valid_o, 1);
            check("hold_addr", addr_o, prev_a);
            check("hold_pad", pad_o, prev_p);
            check("hold_last", last_o, prev_l);
         end
         if (addr_valid_o && addr_ready_i && !abort_i) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat actual addr=%0h required no beat", addr_o);
            end else begin
               logic [17:0] e;
               e = exp_q.pop_front();
               check("beat_addr", addr_o, e[17:2]);
               check("beat_pad", pad_o, e[1]);
               check("beat_last", last_o, e[0]);
            end
            acc_cnt++;
         end
         prev_v  = addr_valid_o;
         prev_r  = addr_ready_i;
         prev_ab = abort_i;
         prev_a  = addr_o;
         prev_p  = pad_o;
         prev_l  = last_o;
      end
   end

   // reference model: tile walk straight from the address formula
   task automatic push_model(input int mm, input int nn, input logic [15:0] bb,
                             input logic [15:0] pp, input bit cm, output int beats);
      longint p, a;
      int tr, tc, k, ro, co, r, outer_n, inner_n;
      p  = (pp == 0) ? longint'(nn * D) : longint'(pp);
      tr = (mm + H - 1) / H;
      tc = (nn + E - 1) / E;
      beats = tr * tc * H;
      outer_n = cm ? tc : tr;
      inner_n = cm ? tr : tc;
      k = 0;
      for (int o = 0; o < outer_n; o++) begin
         for (int ii = 0; ii < inner_n; ii++) begin
            ro = cm ? ii : o;
            co = cm ? o : ii;
            for (int i = 0; i < H; i++) begin
               r = ro * H + i;
               a = longint'(bb) + longint'(r) * p + longint'(co * E * D);
               exp_q.push_back({a[15:0], (r >= mm), (k == beats - 1)});
               k++;
            end
         end
      end
   endtask

   // driver tasks
   task automatic pulse_start(input int mm, input int nn, input logic [15:0] bb,
                              input logic [15:0] pp, input bit cm);
      @(posedge clk);
      #1;
      m = mm[15:0];
      n = nn[15:0];
      base_addr = bb;
      row_pitch = pp;
      col_major_i = cm;
      start_i = 1'b1;
      s_cyc = cyc;
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic run_walk(input int mm, input int nn, input logic [15:0] bb,
                           input logic [15:0] pp, input bit cm, input bit timed, input bit poke);
      int beats, a0, d0, k, lat;
      push_model(mm, nn, bb, pp, cm, beats);
      a0 = acc_cnt;
      d0 = done_seen;
      pulse_start(mm, nn, bb, pp, cm);
      k = 0;
      do begin
         @(negedge clk);
         k++;
         if (k == 1) check("busy_after_start", busy_o, 1);
      end while (!addr_valid_o && !done_o && k < 20);
      check("first_response_latency", k, 2);
      if (poke) begin
         @(posedge clk);
         #1;
         m = 16'd1;
         n = 16'd1;
         base_addr = 16'hffff;
         start_i = 1'b1;
         @(posedge clk);
         #1;
         start_i = 1'b0;
      end
      k = 0;
      while (done_seen == d0 && k < 3000) begin
         @(posedge clk);
         k++;
      end
      check("walk_done", (done_seen != d0), 1);
      if (done_seen == d0) begin
         #1 abort_i = 1'b1;
         @(posedge clk);
         #1 abort_i = 1'b0;
         exp_q.delete();
      end
      check("walk_done_count", done_seen - d0, 1);
      check("walk_beats", acc_cnt - a0, beats);
      check("walk_queue_empty", exp_q.size(), 0);
      if (timed) begin
         lat = (beats == 0) ? 2 : (beats / H) * (H + 1) + 1;
         check("done_latency", done_cyc - s_cyc, lat);
      end
      @(negedge clk);
      check("done_one_cycle", done_o, 0);
      check("idle_busy", busy_o, 0);
   endtask

   initial begin
      int beats, a0, d0, k;
      int rm, rn;
      logic [15:0] rb, rp;
      bit rc;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_valid", addr_valid_o, 0);
      check("rst_addr", addr_o, 0);
      check("rst_pad", pad_o, 0);
      check("rst_last", last_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // directed walks with ready held high
      run_walk(4, 32, 16'h0100, 16'h0000, 1'b0, 1'b1, 1'b0);
      run_walk(8, 64, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
      run_walk(8, 64, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
      run_walk(6, 32, 16'h0000, 16'h0080, 1'b0, 1'b1, 1'b0);
      run_walk(0, 32, 16'h0040, 16'h0000, 1'b0, 1'b1, 1'b0);
      run_walk(5, 0, 16'h0040, 16'h0000, 1'b0, 1'b1, 1'b0);
      run_walk(5, 40, 16'hfff0, 16'h0000, 1'b1, 1'b1, 1'b0);

      // backpressure on beat 2
      stall_at = acc_cnt + 1;
      run_walk(4, 32, 16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef MEM_ADDR_GEN_PERF_EN
      check("stall_cnt", stall_cnt_o, 3);
`endif
      stall_at = -1;

      // start while busy is ignored
      run_walk(8, 64, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1);

      // abort after beat 5
      push_model(8, 64, 16'h0080, 16'h0000, 1'b0, beats);
      a0 = acc_cnt;
      d0 = done_seen;
      pulse_start(8, 64, 16'h0080, 16'h0000, 1'b0);
      k = 0;
      while (acc_cnt - a0 < 5 && k < 200) begin
         @(posedge clk);
         k++;
      end
      #1 abort_i = 1'b1;
      @(posedge clk);
      #1 abort_i = 1'b0;
      @(negedge clk);
      check("abort_valid", addr_valid_o, 0);
      check("abort_busy", busy_o, 0);
      check("abort_remaining", exp_q.size(), 11);
      exp_q.delete();
      repeat (4) @(negedge clk);
      check("abort_no_done", done_seen - d0, 0);
      run_walk(8, 64, 16'h0080, 16'h0000, 1'b0, 1'b1, 1'b0);

      // asynchronous reset mid-walk
      push_model(8, 64, 16'h0300, 16'h0000, 1'b0, beats);
      a0 = acc_cnt;
      d0 = done_seen;
      pulse_start(8, 64, 16'h0300, 16'h0000, 1'b0);
      k = 0;
      while (acc_cnt - a0 < 3 && k < 200) begin
         @(posedge clk);
         k++;
      end
      #3 reset_n = 1'b0;
      #1;
      check("arst_valid", addr_valid_o, 0);
      check("arst_addr", addr_o, 0);
      check("arst_pad", pad_o, 0);
      check("arst_last", last_o, 0);
      check("arst_busy", busy_o, 0);
      check("arst_done", done_o, 0);
      exp_q.delete();
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("arst_no_done", done_seen - d0, 0);
      run_walk(4, 32, 16'h0300, 16'h0000, 1'b0, 1'b1, 1'b0);

      // randomized walks with random ready
      rand_ready = 1'b1;
      repeat (20) begin
         rm = $urandom_range(0, 13);
         rn = $urandom_range(0, 100);
         rb = 16'($urandom);
         rp = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'hffff));
         rc = 1'($urandom_range(0, 1));
         run_walk(rm, rn, rb, rp, rc, 1'b0, 1'b0);
      end
      rand_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
